// File: rtl/pulse_gen_mc.sv
// Multi-channel PWM / one-shot pulse generator; outputs registered, no backpressure.
// Define PULSE_GEN_CLAMP_EN to clamp transferred period/duty to PERIOD_MAX.
module pulse_gen_mc #(
  parameter int N          = 26,
  parameter int CH         = 4,
  parameter int PERIOD_MAX = 50000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   enable,
  input  logic [CH-1:0]   mode,
  input  logic [CH-1:0]   trigger,
  input  logic [CH-1:0]   load,
  input  logic [CH*N-1:0] period,
  input  logic [CH*N-1:0] duty,
  output logic [CH-1:0]   pulse_out,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   period_end
);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [N-1:0] lim(input logic [N-1:0] v);
`ifdef PULSE_GEN_CLAMP_EN
    if (64'(v) > 64'(PERIOD_MAX)) lim = N'(PERIOD_MAX);
    else                          lim = v;
`else
    lim = v;
`endif
  endfunction

  for (genvar k = 0; k < CH; k++) begin : g_ch
    state_t       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d, ap_q, ap_d, ad_q, ad_d, pp_q, pp_d, pd_q, pd_d;
    logic         pend_q, pend_d, oneshot_q, oneshot_d;
    logic         pulse_q, pulse_d, busy_q, busy_d, pend_end_q, pend_end_d;
    logic [N-1:0] p_in, d_in, pe_q, pe_d;
    logic         last, xfer;

    assign p_in = period[k*N +: N];
    assign d_in = duty[k*N +: N];
    assign pe_q = (ap_q == '0) ? N'(1) : ap_q;
    assign last = (state_q == RUN) && (cnt_q == pe_q - N'(1));
    // A load coinciding with a transfer point bypasses the pending registers.
    assign xfer = (load[k] | pend_q) & ((state_q == IDLE) | last);

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ap_d      = ap_q;
      ad_d      = ad_q;
      pp_d      = pp_q;
      pd_d      = pd_q;
      pend_d    = pend_q;
      oneshot_d = oneshot_q;

      if (load[k]) begin
        pp_d   = p_in;
        pd_d   = d_in;
        pend_d = 1'b1;
      end
      if (xfer) begin
        ap_d   = lim(load[k] ? p_in : pp_q);
        ad_d   = lim(load[k] ? d_in : pd_q);
        pend_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (enable[k] && (!mode[k] || trigger[k])) begin
            state_d   = RUN;
            oneshot_d = mode[k];
          end
        end
        RUN: begin
          if (last) begin
            cnt_d = '0;
            if (oneshot_q || !enable[k]) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + N'(1);
          end
        end
        default: state_d = IDLE;
      endcase

      pe_d       = (ap_d == '0) ? N'(1) : ap_d;
      busy_d     = (state_d == RUN);
      pulse_d    = busy_d && (cnt_d < ad_d);
      pend_end_d = busy_d && (cnt_d == pe_d - N'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q    <= IDLE;
        cnt_q      <= '0;
        ap_q       <= '0;
        ad_q       <= '0;
        pp_q       <= '0;
        pd_q       <= '0;
        pend_q     <= 1'b0;
        oneshot_q  <= 1'b0;
        pulse_q    <= 1'b0;
        busy_q     <= 1'b0;
        pend_end_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        ap_q       <= ap_d;
        ad_q       <= ad_d;
        pp_q       <= pp_d;
        pd_q       <= pd_d;
        pend_q     <= pend_d;
        oneshot_q  <= oneshot_d;
        pulse_q    <= pulse_d;
        busy_q     <= busy_d;
        pend_end_q <= pend_end_d;
      end
    end

    assign pulse_out[k]  = pulse_q;
    assign busy[k]       = busy_q;
    assign period_end[k] = pend_end_q;
  end

endmodule

// File: tb/tb_pulse_gen_mc.sv
// Scoreboard bench for pulse_gen_mc: expected {pulse,busy,period_end} queued per cycle.
module tb_pulse_gen_mc;
  localparam int N  = 26;
  localparam int CH = 4;

  logic            clk;
  logic            reset;
  logic [CH-1:0]   enable, mode, trigger, load;
  logic [CH*N-1:0] period, duty;
  logic [CH-1:0]   pulse_out, busy, period_end;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  pulse_gen_mc #(.N(N), .CH(CH), .PERIOD_MAX(20)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .trigger(trigger),
    .load(load), .period(period), .duty(duty),
    .pulse_out(pulse_out), .busy(busy), .period_end(period_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_load(input int ch, input int p, input int d);
    period[ch*N +: N] = N'(p);
    duty[ch*N +: N]   = N'(d);
    load[ch]          = 1'b1;
  endtask

  task automatic step(input int ch, input logic p, input logic b, input logic e,
                      input string tag);
    logic [2:0] exp;
    exp_q.push_back({p, b, e});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    chk(tag, {29'b0, pulse_out[ch], busy[ch], period_end[ch]}, {29'b0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pe;
    reset = 1'b1; enable = '0; mode = '0; trigger = '0; load = '0;
    period = '0; duty = '0;
    #2;
    chk("rst_pulse", 32'(pulse_out), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_pend",  32'(period_end), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ch0 continuous 10/3, then reload 4/2 mid-period, then disable
    set_load(0, 10, 3);
    step(0, 0, 0, 0, "c0_load_idle");
    load = '0;
    enable[0] = 1'b1;
    for (int i = 0; i <= 25; i++) step(0, (i % 10) < 3, 1, (i % 10) == 9, "c0_run10");
    set_load(0, 4, 2);
    for (int i = 26; i <= 29; i++) begin
      step(0, (i % 10) < 3, 1, (i % 10) == 9, "c0_finish10");
      load = '0;
    end
    for (int j = 0; j <= 12; j++) step(0, (j % 4) < 2, 1, (j % 4) == 3, "c0_run4");
    enable[0] = 1'b0;
    for (int j = 13; j <= 15; j++) step(0, (j % 4) < 2, 1, (j % 4) == 3, "c0_drain");
    step(0, 0, 0, 0, "c0_idle");
    step(0, 0, 0, 0, "c0_idle2");

    // ch1 one-shot 8/5, second trigger and enable drop ignored
    mode[1] = 1'b1;
    set_load(1, 8, 5);
    enable[1] = 1'b1;
    step(1, 0, 0, 0, "c1_no_trig");
    load = '0;
    trigger[1] = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      step(1, i < 5, 1, i == 7, "c1_oneshot");
      trigger[1] = (i == 1);
      if (i == 3) enable[1] = 1'b0;
    end
    step(1, 0, 0, 0, "c1_done");
    step(1, 0, 0, 0, "c1_done2");

    // ch2 duty corner cases, loads landing on the period boundary
    set_load(2, 10, 0);
    enable[2] = 1'b1;
    for (int i = 0; i <= 19; i++) begin
      step(2, 0, 1, (i % 10) == 9, "c2_duty0");
      load = '0;
    end
    set_load(2, 10, 12);
    for (int i = 0; i <= 19; i++) begin
      step(2, 1, 1, (i % 10) == 9, "c2_duty12");
      load = '0;
    end
    set_load(2, 0, 1);
    for (int i = 0; i <= 4; i++) begin
      step(2, 1, 1, 1, "c2_period0");
      load = '0;
    end
    enable[2] = 1'b0;
    step(2, 0, 0, 0, "c2_idle");

    // ch3 async reset during high phase
    set_load(3, 10, 3);
    enable[3] = 1'b1;
    for (int i = 0; i <= 2; i++) begin
      step(3, 1, 1, 0, "c3_run");
      load = '0;
    end
    #2;
    reset = 1'b1;
    enable[3] = 1'b0;
    #1;
    chk("c3_async_pulse", 32'(pulse_out), 32'd0);
    chk("c3_async_busy",  32'(busy),      32'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(3, 0, 0, 0, "c3_post_rst");
    enable[3] = 1'b1;
    for (int i = 0; i < 3; i++) step(3, 0, 1, 1, "c3_ap0");
    enable[3] = 1'b0;
    step(3, 0, 0, 0, "c3_idle");

    // ch1 period 100 duty 5: clamped to 20 when the clamp build is selected
`ifdef PULSE_GEN_CLAMP_EN
    pe = 20;
`else
    pe = 100;
`endif
    mode[1] = 1'b0;
    set_load(1, 100, 5);
    enable[1] = 1'b1;
    for (int i = 0; i < pe + 5; i++) begin
      step(1, (i % pe) < 5, 1, (i % pe) == pe - 1, "c1_clamp");
      load = '0;
    end
    chk("other_idle", 32'(busy), 32'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
